// File: rtl/dispatch_pkg.sv
// Shared types and constants for the multi-core instruction dispatcher.
package dispatch_pkg;

  typedef enum logic [1:0] {
    DISP_DIRECTED  = 2'b00,
    DISP_BROADCAST = 2'b01,
    DISP_RR        = 2'b10,
    DISP_RSVD      = 2'b11
  } disp_mode_e;

  localparam int DROP_W_DEF = 8;
  localparam logic [DROP_W_DEF-1:0] DROP_SAT = '1;

endpackage

// File: rtl/instr_fifo.sv
// First-word-fall-through instruction FIFO with synchronous flush and occupancy count.
module instr_fifo #(
  parameter int DEPTH   = 4,
  parameter int INSTR_W = 32,
  parameter int CNT_W   = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic               flush,
  input  logic               push,
  input  logic               pop,
  input  logic [INSTR_W-1:0] din,
  output logic [INSTR_W-1:0] dout,
  output logic [CNT_W-1:0]   count,
  output logic               full,
  output logic               empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [INSTR_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic               do_push;
  logic               do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full && resetN && !flush;
  assign do_pop  = pop && !empty && resetN && !flush;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!resetN || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage is left unreset; only the pointers and count define what is visible.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/mp_instr_dispatch.sv
// Routes one instruction stream into per-core FIFOs using directed, broadcast or round-robin modes.
module mp_instr_dispatch
  import dispatch_pkg::*;
#(
  parameter int N          = 3,
  parameter int DEPTH      = 4,
  parameter int INSTR_W    = 32,
  parameter int CORE_SEL_W = (N <= 1) ? 1 : $clog2(N),
  parameter int CNT_W      = $clog2(DEPTH + 1),
  parameter int DROP_W     = DROP_W_DEF
) (
  input  logic                          clk,
  input  logic                          resetN,
  input  logic                          flush,
  input  logic                          instr_valid,
  input  logic [INSTR_W-1:0]            instr_word,
  input  logic [CORE_SEL_W-1:0]         instr_core_sel,
  input  logic [1:0]                    instr_mode,
  output logic                          instr_ready,
  output logic [N-1:0]                  core_instr_valid,
  output logic [N-1:0][INSTR_W-1:0]     core_instr_word,
  input  logic [N-1:0]                  core_instr_ready,
  output logic [N-1:0][CNT_W-1:0]       fifo_count,
  output logic [N-1:0]                  fifo_full_vec,
  output logic [N-1:0]                  fifo_empty_vec,
  output logic [CORE_SEL_W-1:0]         rr_ptr_dbg,
  output logic [DROP_W-1:0]             drop_count
);

  localparam logic [DROP_W-1:0] DROP_MAX = '1;

  disp_mode_e            mode;
  logic [N-1:0]          push_vec;
  logic                  accept;
  logic                  drop;
  logic                  rr_adv;
  logic [CORE_SEL_W-1:0] rr_ptr;

  assign mode       = disp_mode_e'(instr_mode);
  assign rr_ptr_dbg = rr_ptr;

  // Ready only looks at registered full flags, so a full FIFO never takes a push even when popping.
  always_comb begin
    instr_ready = 1'b0;
    push_vec    = '0;
    accept      = 1'b0;
    drop        = 1'b0;
    rr_adv      = 1'b0;
    if (resetN && !flush) begin
      case (mode)
        DISP_BROADCAST: begin
          instr_ready = ~|fifo_full_vec;
          accept      = instr_valid && instr_ready;
          push_vec    = {N{accept}};
        end
        DISP_RR: begin
          instr_ready      = !fifo_full_vec[rr_ptr];
          accept           = instr_valid && instr_ready;
          push_vec[rr_ptr] = accept;
          rr_adv           = accept;
        end
        default: begin
          if (int'(instr_core_sel) < N) begin
            instr_ready              = !fifo_full_vec[instr_core_sel];
            accept                   = instr_valid && instr_ready;
            push_vec[instr_core_sel] = accept;
          end else begin
            instr_ready = 1'b1;
            accept      = instr_valid;
            drop        = accept;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!resetN || flush) begin
      rr_ptr <= '0;
    end else if (rr_adv) begin
      rr_ptr <= (rr_ptr == CORE_SEL_W'(N - 1)) ? '0 : rr_ptr + 1'b1;
    end
  end

  // Flush deliberately leaves the drop statistic alone.
  always_ff @(posedge clk) begin
    if (!resetN) begin
      drop_count <= '0;
    end else if (drop && drop_count != DROP_MAX) begin
      drop_count <= drop_count + 1'b1;
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_core
    instr_fifo #(
      .DEPTH  (DEPTH),
      .INSTR_W(INSTR_W),
      .CNT_W  (CNT_W)
    ) u_fifo (
      .clk   (clk),
      .resetN(resetN),
      .flush (flush),
      .push  (push_vec[i]),
      .pop   (core_instr_ready[i]),
      .din   (instr_word),
      .dout  (core_instr_word[i]),
      .count (fifo_count[i]),
      .full  (fifo_full_vec[i]),
      .empty (fifo_empty_vec[i])
    );
    assign core_instr_valid[i] = !fifo_empty_vec[i];
  end

endmodule

// File: tb/tb_mp_instr_dispatch.sv
// Self-checking bench for mp_instr_dispatch: vector table, corner-case sequences and a queue-based random model.
module tb_mp_instr_dispatch;

  logic             clk = 1'b0;
  logic             resetN;
  logic             flush;
  logic             instr_valid;
  logic [31:0]      instr_word;
  logic [1:0]       instr_core_sel;
  logic [1:0]       instr_mode;
  logic             instr_ready;
  logic [2:0]       core_instr_valid;
  logic [2:0][31:0] core_instr_word;
  logic [2:0]       core_instr_ready;
  logic [2:0][2:0]  fifo_count;
  logic [2:0]       fifo_full_vec;
  logic [2:0]       fifo_empty_vec;
  logic [1:0]       rr_ptr_dbg;
  logic [7:0]       drop_count;

  always #5 clk = ~clk;

  mp_instr_dispatch #(.N(3), .DEPTH(4), .INSTR_W(32), .DROP_W(8)) dut (
    .clk(clk), .resetN(resetN), .flush(flush),
    .instr_valid(instr_valid), .instr_word(instr_word),
    .instr_core_sel(instr_core_sel), .instr_mode(instr_mode),
    .instr_ready(instr_ready),
    .core_instr_valid(core_instr_valid), .core_instr_word(core_instr_word),
    .core_instr_ready(core_instr_ready),
    .fifo_count(fifo_count), .fifo_full_vec(fifo_full_vec),
    .fifo_empty_vec(fifo_empty_vec), .rr_ptr_dbg(rr_ptr_dbg),
    .drop_count(drop_count)
  );

  // Reference: one queue per core, a round-robin index and a saturating drop tally.
  logic [31:0] q  [3][$];
  logic [31:0] rx [3][$];
  int  m_rr;
  int  m_drop;
  int  total;
  int  bad;
  logic seen_ready;
  logic collect;

  typedef struct {
    logic        valid;
    logic [1:0]  mode;
    logic [1:0]  sel;
    logic [31:0] word;
    logic [2:0]  cready;
    logic        exp_ready;
    int          exp_cnt1;
    logic        exp_valid1;
    logic [31:0] exp_head1;
  } vec_t;

  vec_t tbl [10];

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%0h want=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic model_ready();
    if (!resetN || flush) return 1'b0;
    case (instr_mode)
      2'd1:    return (q[0].size() < 4) && (q[1].size() < 4) && (q[2].size() < 4);
      2'd2:    return q[m_rr].size() < 4;
      default: return (instr_core_sel < 2'd3) ? (q[instr_core_sel].size() < 4) : 1'b1;
    endcase
  endfunction

  task automatic apply_stimulus(input logic v, input logic [1:0] mode, input logic [1:0] sel,
                                input logic [31:0] word, input logic [2:0] cready,
                                input logic fl, input logic rn);
    instr_valid      = v;
    instr_mode       = mode;
    instr_core_sel   = sel;
    instr_word       = word;
    core_instr_ready = cready;
    flush            = fl;
    resetN           = rn;
  endtask

  task automatic check_output();
    for (int i = 0; i < 3; i++) begin
      cmp($sformatf("count%0d", i), 32'(fifo_count[i]), 32'(q[i].size()));
      cmp($sformatf("valid%0d", i), 32'(core_instr_valid[i]), 32'(q[i].size() > 0));
      cmp($sformatf("full%0d", i), 32'(fifo_full_vec[i]), 32'(q[i].size() == 4));
      cmp($sformatf("empty%0d", i), 32'(fifo_empty_vec[i]), 32'(q[i].size() == 0));
      if (q[i].size() > 0) cmp($sformatf("head%0d", i), core_instr_word[i], q[i][0]);
    end
    cmp("rr_ptr", 32'(rr_ptr_dbg), 32'(m_rr));
    cmp("drop_count", 32'(drop_count), 32'(m_drop));
  endtask

  // One clock: check ready before the edge, advance the model at the edge, check state after it.
  task automatic tick();
    logic exp_r;
    @(negedge clk);
    exp_r = model_ready();
    cmp("instr_ready", 32'(instr_ready), 32'(exp_r));
    seen_ready = instr_ready;
    if (collect)
      for (int i = 0; i < 3; i++)
        if (core_instr_valid[i] && core_instr_ready[i]) rx[i].push_back(core_instr_word[i]);
    @(posedge clk);
    if (!resetN || flush) begin
      for (int i = 0; i < 3; i++) q[i].delete();
      m_rr = 0;
      if (!resetN) m_drop = 0;
    end else begin
      for (int i = 0; i < 3; i++)
        if (core_instr_ready[i] && q[i].size() > 0) void'(q[i].pop_front());
      if (instr_valid && exp_r) begin
        case (instr_mode)
          2'd1: for (int i = 0; i < 3; i++) q[i].push_back(instr_word);
          2'd2: begin
            q[m_rr].push_back(instr_word);
            m_rr = (m_rr + 1) % 3;
          end
          default:
            if (instr_core_sel < 2'd3) q[instr_core_sel].push_back(instr_word);
            else if (m_drop < 255) m_drop++;
        endcase
      end
    end
    #1;
    check_output();
  endtask

  task automatic do_reset();
    apply_stimulus(1'b0, 2'd0, 2'd0, 32'h0, 3'b000, 1'b0, 1'b0);
    tick();
    apply_stimulus(1'b0, 2'd0, 2'd0, 32'h0, 3'b000, 1'b0, 1'b1);
  endtask

  initial begin
    total = 0; bad = 0; m_rr = 0; m_drop = 0; collect = 1'b0; seen_ready = 1'b0;
    apply_stimulus(1'b0, 2'd0, 2'd0, 32'h0, 3'b000, 1'b0, 1'b0);
    tick();
    do_reset();

    // Directed fill of core 1, blocked 5th word, then drain with the 5th admitted once not full.
    tbl[0] = '{1'b1, 2'd0, 2'd1, 32'hA0, 3'b000, 1'b1, 1, 1'b1, 32'hA0};
    tbl[1] = '{1'b1, 2'd0, 2'd1, 32'hA1, 3'b000, 1'b1, 2, 1'b1, 32'hA0};
    tbl[2] = '{1'b1, 2'd0, 2'd1, 32'hA2, 3'b000, 1'b1, 3, 1'b1, 32'hA0};
    tbl[3] = '{1'b1, 2'd0, 2'd1, 32'hA3, 3'b000, 1'b1, 4, 1'b1, 32'hA0};
    tbl[4] = '{1'b1, 2'd0, 2'd1, 32'hA4, 3'b000, 1'b0, 4, 1'b1, 32'hA0};
    tbl[5] = '{1'b1, 2'd0, 2'd1, 32'hA4, 3'b010, 1'b0, 3, 1'b1, 32'hA1};
    tbl[6] = '{1'b1, 2'd0, 2'd1, 32'hA4, 3'b010, 1'b1, 3, 1'b1, 32'hA2};
    tbl[7] = '{1'b0, 2'd0, 2'd1, 32'h00, 3'b010, 1'b1, 2, 1'b1, 32'hA3};
    tbl[8] = '{1'b0, 2'd0, 2'd1, 32'h00, 3'b010, 1'b1, 1, 1'b1, 32'hA4};
    tbl[9] = '{1'b0, 2'd0, 2'd1, 32'h00, 3'b010, 1'b1, 0, 1'b0, 32'h00};
    for (int k = 0; k < 10; k++) begin
      apply_stimulus(tbl[k].valid, tbl[k].mode, tbl[k].sel, tbl[k].word, tbl[k].cready, 1'b0, 1'b1);
      tick();
      cmp($sformatf("tbl%0d_ready", k), 32'(seen_ready), 32'(tbl[k].exp_ready));
      cmp($sformatf("tbl%0d_cnt1", k), 32'(fifo_count[1]), 32'(tbl[k].exp_cnt1));
      cmp($sformatf("tbl%0d_valid1", k), 32'(core_instr_valid[1]), 32'(tbl[k].exp_valid1));
      if (tbl[k].exp_valid1) cmp($sformatf("tbl%0d_head1", k), core_instr_word[1], tbl[k].exp_head1);
    end

    // Broadcast must not partially push while core 0 is full.
    do_reset();
    for (int k = 0; k < 4; k++) begin
      apply_stimulus(1'b1, 2'd0, 2'd0, 32'hB0 + k, 3'b000, 1'b0, 1'b1);
      tick();
    end
    apply_stimulus(1'b1, 2'd1, 2'd0, 32'hBB, 3'b000, 1'b0, 1'b1);
    tick();
    cmp("bc_blocked_ready", 32'(seen_ready), 32'd0);
    cmp("bc_blocked_cnts", 32'(fifo_count), {23'd0, 3'd0, 3'd0, 3'd4});
    apply_stimulus(1'b0, 2'd1, 2'd0, 32'h0, 3'b001, 1'b0, 1'b1);
    tick();
    apply_stimulus(1'b1, 2'd1, 2'd0, 32'hBC, 3'b000, 1'b0, 1'b1);
    tick();
    cmp("bc_ready", 32'(seen_ready), 32'd1);
    cmp("bc_cnts", 32'(fifo_count), {23'd0, 3'd1, 3'd1, 3'd4});

    // Round-robin wrap with every core consuming.
    do_reset();
    collect = 1'b1;
    for (int k = 0; k < 7; k++) begin
      apply_stimulus(1'b1, 2'd2, 2'd0, 32'h10 + k, 3'b111, 1'b0, 1'b1);
      tick();
    end
    for (int k = 0; k < 3; k++) begin
      apply_stimulus(1'b0, 2'd2, 2'd0, 32'h0, 3'b111, 1'b0, 1'b1);
      tick();
    end
    collect = 1'b0;
    cmp("rr_end_ptr", 32'(rr_ptr_dbg), 32'd1);
    cmp("rr_rx0_n", rx[0].size(), 32'd3);
    cmp("rr_rx1_n", rx[1].size(), 32'd2);
    cmp("rr_rx2_n", rx[2].size(), 32'd2);
    if (rx[0].size() == 3) begin
      cmp("rr_rx0_0", rx[0][0], 32'h10);
      cmp("rr_rx0_1", rx[0][1], 32'h13);
      cmp("rr_rx0_2", rx[0][2], 32'h16);
    end
    if (rx[1].size() == 2) begin
      cmp("rr_rx1_0", rx[1][0], 32'h11);
      cmp("rr_rx1_1", rx[1][1], 32'h14);
    end
    if (rx[2].size() == 2) begin
      cmp("rr_rx2_0", rx[2][0], 32'h12);
      cmp("rr_rx2_1", rx[2][1], 32'h15);
    end

    // Invalid select: every word dropped, counter pins at 255.
    do_reset();
    for (int k = 0; k < 300; k++) begin
      apply_stimulus(1'b1, 2'd0, 2'd3, 32'(k), 3'b000, 1'b0, 1'b1);
      tick();
    end
    cmp("drop_sat", 32'(drop_count), 32'd255);
    cmp("drop_no_push", 32'(fifo_count), 32'd0);

    // Flush mid-burst keeps drops; reset mid-burst clears them.
    do_reset();
    for (int k = 0; k < 5; k++) begin
      apply_stimulus(1'b1, 2'd3, 2'd3, 32'h0, 3'b000, 1'b0, 1'b1);
      tick();
    end
    for (int k = 0; k < 6; k++) begin
      apply_stimulus(1'b1, 2'd2, 2'd0, 32'hC0 + k, 3'b000, 1'b0, 1'b1);
      tick();
    end
    cmp("pre_flush_cnts", 32'(fifo_count), {23'd0, 3'd2, 3'd2, 3'd2});
    apply_stimulus(1'b1, 2'd2, 2'd0, 32'hCF, 3'b111, 1'b1, 1'b1);
    tick();
    cmp("flush_ready", 32'(seen_ready), 32'd0);
    cmp("flush_cnts", 32'(fifo_count), 32'd0);
    cmp("flush_drop", 32'(drop_count), 32'd5);
    for (int k = 0; k < 6; k++) begin
      apply_stimulus(1'b1, 2'd2, 2'd0, 32'hD0 + k, 3'b000, 1'b0, 1'b1);
      tick();
    end
    apply_stimulus(1'b1, 2'd2, 2'd0, 32'hDF, 3'b000, 1'b0, 1'b0);
    tick();
    cmp("rst_ready", 32'(seen_ready), 32'd0);
    cmp("rst_drop", 32'(drop_count), 32'd0);
    apply_stimulus(1'b0, 2'd0, 2'd0, 32'h0, 3'b000, 1'b0, 1'b1);
    tick();
    cmp("rst_no_valid", 32'(core_instr_valid), 32'd0);

    // Random traffic against the queue model.
    for (int k = 0; k < 2500; k++) begin
      apply_stimulus(($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                     $urandom, 3'($urandom_range(0, 7)), ($urandom_range(0, 59) == 0),
                     ($urandom_range(0, 249) != 0));
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
